// File: rtl/fifo_pattern_checker_if.sv
// rtl/fifo_pattern_checker_if.sv - FIFO read-port bundle between the FIFO under test and its checker
interface fifo_pattern_checker_if #(
  parameter int HALF_W = 16
);
  logic                rst_busy_i;
  logic                empty_i;
  logic [2*HALF_W-1:0] rdata_i;
  logic                rd_valid_i;
  logic                rd_en_o;

  modport master (
    input  rst_busy_i,
    input  empty_i,
    input  rdata_i,
    input  rd_valid_i,
    output rd_en_o
  );

  modport slave (
    output rst_busy_i,
    output empty_i,
    output rdata_i,
    output rd_valid_i,
    input  rd_en_o
  );
endinterface

// File: rtl/fifo_pattern_checker.sv
// rtl/fifo_pattern_checker.sv - read-side consumer and continuity checker for the counter FIFO test path
module fifo_pattern_checker #(
  parameter int HALF_W         = 16,
  parameter int RD_GAP         = 0,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BLINK_BITS     = 20
) (
  input  logic                   led_clk,
  input  logic                   sys_rst,
  input  logic                   enable_i,
  fifo_pattern_checker_if.master rd,
  output logic                   error_o,
  output logic [2*HALF_W-1:0]    err_word_o,
  output logic [HALF_W-1:0]      err_exp_o,
  output logic [31:0]            words_ok_o,
  output logic                   stall_o,
  output logic                   locked_o,
  output logic                   led_blink_o,
  output logic                   led_error_o
);

  localparam int GAP_W = (RD_GAP > 0) ? $clog2(RD_GAP + 1) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [GAP_W-1:0]      gap_q;
  logic [WD_W-1:0]       wd_q;
  logic [HALF_W-1:0]     exp_q;
  logic [BLINK_BITS-1:0] blink_q;

  logic [HALF_W-1:0]     upper;
  logic [HALF_W-1:0]     lower;
  logic [HALF_W-1:0]     upper_inc;
  logic [HALF_W-1:0]     lower_inc;
  logic [HALF_W-1:0]     err_exp_sel;
  logic                  active;
  logic                  chk_valid;
  logic                  word_bad;

  assign upper     = rd.rdata_i[2*HALF_W-1:HALF_W];
  assign lower     = rd.rdata_i[HALF_W-1:0];
  assign upper_inc = upper + HALF_W'(1);
  assign lower_inc = lower + HALF_W'(1);
  assign active    = (state_q != IDLE);
  assign chk_valid = active && rd.rd_valid_i;

  // The SYNC word only has to be self-consistent; RUN words must also continue the sequence.
  assign word_bad    = (lower != upper_inc) || ((state_q == RUN) && (upper != exp_q));
  assign err_exp_sel = (state_q == SYNC) ? upper_inc : exp_q;

  assign rd.rd_en_o  = active && !rd.empty_i && enable_i && !rd.rst_busy_i && (gap_q == '0);
  assign led_error_o = error_o | stall_o;

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!rd.rst_busy_i && enable_i) state_d = SYNC;
      SYNC: begin
        if (rd.rst_busy_i)      state_d = IDLE;
        else if (rd.rd_valid_i) state_d = RUN;
      end
      RUN:  if (rd.rst_busy_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gap_q <= '0;
    end else if (rd.rd_en_o) begin
      gap_q <= GAP_W'(RD_GAP);
    end else if (gap_q != '0) begin
      gap_q <= gap_q - GAP_W'(1);
    end
  end

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      exp_q      <= '0;
      error_o    <= 1'b0;
      err_word_o <= '0;
      err_exp_o  <= '0;
      words_ok_o <= '0;
      locked_o   <= 1'b0;
    end else begin
      if (chk_valid) begin
        // Resync on every word so one bad word does not mask the rest of the stream.
        exp_q <= lower_inc;
        if (word_bad) begin
          error_o <= 1'b1;
          if (!error_o) begin
            err_word_o <= rd.rdata_i;
            err_exp_o  <= err_exp_sel;
          end
        end else if (words_ok_o != 32'hFFFF_FFFF) begin
          words_ok_o <= words_ok_o + 32'd1;
        end
      end
      if ((state_q == SYNC) && rd.rd_valid_i) begin
        locked_o <= 1'b1;
      end
      if (active && rd.rst_busy_i) begin
        locked_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wd_q    <= '0;
      stall_o <= 1'b0;
    end else if ((state_q != RUN) || rd.rst_busy_i || rd.rd_valid_i) begin
      wd_q <= '0;
    end else if (enable_i && (wd_q != WD_W'(TIMEOUT_CYCLES))) begin
      wd_q <= wd_q + WD_W'(1);
      if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        stall_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      blink_q     <= '0;
      led_blink_o <= 1'b0;
    end else begin
      blink_q <= blink_q + BLINK_BITS'(1);
      if (&blink_q) begin
        led_blink_o <= ~led_blink_o;
      end
    end
  end

endmodule

// File: tb/tb_fifo_pattern_checker.sv
// tb/tb_fifo_pattern_checker.sv - self-checking bench for fifo_pattern_checker
module tb_fifo_pattern_checker;

  localparam int HW = 16;

  typedef struct {
    logic [31:0] w;
    int          rem;
  } pend_t;

  logic led_clk = 1'b0;
  logic sys_rst;
  logic a_enable;
  logic b_enable;

  fifo_pattern_checker_if #(.HALF_W(HW)) a_if ();
  fifo_pattern_checker_if #(.HALF_W(HW)) b_if ();

  logic        a_error, a_stall, a_locked, a_blink, a_led_error;
  logic [31:0] a_err_word, a_ok;
  logic [15:0] a_err_exp;
  logic        b_error, b_stall, b_locked, b_blink, b_led_error;
  logic [31:0] b_err_word, b_ok;
  logic [15:0] b_err_exp;

  fifo_pattern_checker #(.HALF_W(HW), .RD_GAP(0), .TIMEOUT_CYCLES(1024), .BLINK_BITS(4)) u_dut_a (
    .led_clk    (led_clk),
    .sys_rst    (sys_rst),
    .enable_i   (a_enable),
    .rd         (a_if.master),
    .error_o    (a_error),
    .err_word_o (a_err_word),
    .err_exp_o  (a_err_exp),
    .words_ok_o (a_ok),
    .stall_o    (a_stall),
    .locked_o   (a_locked),
    .led_blink_o(a_blink),
    .led_error_o(a_led_error)
  );

  fifo_pattern_checker #(.HALF_W(HW), .RD_GAP(2), .TIMEOUT_CYCLES(1024), .BLINK_BITS(4)) u_dut_b (
    .led_clk    (led_clk),
    .sys_rst    (sys_rst),
    .enable_i   (b_enable),
    .rd         (b_if.master),
    .error_o    (b_error),
    .err_word_o (b_err_word),
    .err_exp_o  (b_err_exp),
    .words_ok_o (b_ok),
    .stall_o    (b_stall),
    .locked_o   (b_locked),
    .led_blink_o(b_blink),
    .led_error_o(b_led_error)
  );

  always #5 led_clk = ~led_clk;

  int checks   = 0;
  int failures = 0;
  int edges    = 0;

  logic [31:0] a_q[$];
  pend_t       a_pend[$];
  int          a_lat     = 1;
  int          a_gap_pct = 0;
  logic        last_a_rd_en;

  logic        b_fire;
  logic [31:0] b_word;
  logic [15:0] b_cnt;
  int          b_idx;
  logic        last_b_rd_en;

  logic        m_first[2];
  logic        m_err[2];
  logic        m_locked[2];
  logic [15:0] m_exp[2];
  logic [15:0] m_err_exp[2];
  logic [31:0] m_err_word[2];
  logic [31:0] m_ok[2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_clear(input int k);
    m_first[k]    = 1'b1;
    m_err[k]      = 1'b0;
    m_locked[k]   = 1'b0;
    m_exp[k]      = 16'd0;
    m_err_exp[k]  = 16'd0;
    m_err_word[k] = 32'd0;
    m_ok[k]       = 32'd0;
  endtask

  task automatic model_resync(input int k);
    m_first[k]  = 1'b1;
    m_locked[k] = 1'b0;
  endtask

  // Each word must be {n, n+1}; after the first it must also continue from the previous lower half.
  task automatic model_word(input int k, input logic [31:0] w);
    logic [15:0] up, lo, up_nx, lo_nx;
    logic        bad;
    up    = w[31:16];
    lo    = w[15:0];
    up_nx = up + 16'd1;
    lo_nx = lo + 16'd1;
    bad   = (lo != up_nx) || (!m_first[k] && (up != m_exp[k]));
    if (bad) begin
      if (!m_err[k]) begin
        m_err_word[k] = w;
        m_err_exp[k]  = m_first[k] ? up_nx : m_exp[k];
      end
      m_err[k] = 1'b1;
    end else if (m_ok[k] != 32'hFFFF_FFFF) begin
      m_ok[k] = m_ok[k] + 32'd1;
    end
    m_exp[k]    = lo_nx;
    m_first[k]  = 1'b0;
    m_locked[k] = 1'b1;
  endtask

  task automatic check_model(input int k, input string tag);
    if (k == 0) begin
      check_val($sformatf("%s.error", tag),    {31'd0, a_error},   {31'd0, m_err[0]});
      check_val($sformatf("%s.words_ok", tag), a_ok,               m_ok[0]);
      check_val($sformatf("%s.err_word", tag), a_err_word,         m_err_word[0]);
      check_val($sformatf("%s.err_exp", tag),  {16'd0, a_err_exp}, {16'd0, m_err_exp[0]});
      check_val($sformatf("%s.locked", tag),   {31'd0, a_locked},  {31'd0, m_locked[0]});
    end else begin
      check_val($sformatf("%s.error", tag),    {31'd0, b_error},   {31'd0, m_err[1]});
      check_val($sformatf("%s.words_ok", tag), b_ok,               m_ok[1]);
      check_val($sformatf("%s.err_word", tag), b_err_word,         m_err_word[1]);
      check_val($sformatf("%s.err_exp", tag),  {16'd0, b_err_exp}, {16'd0, m_err_exp[1]});
      check_val($sformatf("%s.locked", tag),   {31'd0, b_locked},  {31'd0, m_locked[1]});
    end
  endtask

  task automatic check_blink(input string tag);
    check_val(tag, {31'd0, a_blink}, (edges >> 4) & 1);
  endtask

  // One clock cycle, entered and left at the falling edge; FIFO models for both DUTs live here.
  task automatic tick();
    for (int i = 0; i < a_pend.size(); i++) a_pend[i].rem = a_pend[i].rem - 1;
    a_if.rd_valid_i = 1'b0;
    a_if.rdata_i    = $urandom();
    if (a_pend.size() > 0 && a_pend[0].rem == 0) begin
      a_if.rd_valid_i = 1'b1;
      a_if.rdata_i    = a_pend[0].w;
      model_word(0, a_pend[0].w);
      void'(a_pend.pop_front());
    end
    a_if.empty_i = (a_q.size() == 0) || ($urandom_range(99) < a_gap_pct);

    b_if.empty_i    = 1'b0;
    b_if.rd_valid_i = b_fire;
    b_if.rdata_i    = b_fire ? b_word : $urandom();
    if (b_fire) model_word(1, b_word);

    #1;
    last_a_rd_en = a_if.rd_en_o;
    if (a_if.rd_en_o && a_q.size() > 0) begin
      pend_t p;
      p.w   = a_q.pop_front();
      p.rem = a_lat;
      a_pend.push_back(p);
    end
    last_b_rd_en = b_if.rd_en_o;
    b_fire = b_if.rd_en_o;
    if (b_if.rd_en_o) begin
      if (b_idx == 4) b_cnt = b_cnt + 16'd3;
      b_word = {b_cnt, b_cnt + 16'd1};
      b_cnt  = b_cnt + 16'd2;
      b_idx++;
    end
    @(posedge led_clk);
    if (!sys_rst) edges++;
    @(negedge led_clk);
  endtask

  task automatic load_words(input logic [15:0] start, input int n, input int bad_pct);
    logic [15:0] s;
    logic [31:0] w;
    s = start;
    for (int i = 0; i < n; i++) begin
      w = {s, s + 16'd1};
      if ($urandom_range(99) < bad_pct) w = w ^ (32'd1 << $urandom_range(31));
      a_q.push_back(w);
      s = s + 16'd2;
    end
  endtask

  task automatic drain_a(input int en_off_pct);
    int n;
    n = 0;
    while ((a_q.size() != 0 || a_pend.size() != 0) && n < 3000) begin
      a_enable = ($urandom_range(99) >= en_off_pct);
      tick();
      n++;
    end
    check_val("drain_done", a_q.size() + a_pend.size(), 0);
    a_enable = 1'b1;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    a_q.delete();
    a_pend.delete();
    b_fire = 1'b0;
    a_if.rd_valid_i = 1'b0;
    b_if.rd_valid_i = 1'b0;
    repeat (2) @(negedge led_clk);
    sys_rst = 1'b0;
    edges   = 0;
    model_clear(0);
    model_clear(1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt, last, mn, mx, busy_en;
    sys_rst = 1'b1;
    a_enable = 1'b1;
    b_enable = 1'b0;
    a_if.rst_busy_i = 1'b1;
    a_if.empty_i = 1'b1;
    a_if.rd_valid_i = 1'b0;
    a_if.rdata_i = 32'd0;
    b_if.rst_busy_i = 1'b0;
    b_if.empty_i = 1'b0;
    b_if.rd_valid_i = 1'b0;
    b_if.rdata_i = 32'd0;
    b_fire = 1'b0;
    b_word = 32'd0;
    b_cnt = 16'($urandom());
    b_idx = 0;
    model_clear(0);
    model_clear(1);
    repeat (2) @(negedge led_clk);

    check_val("rst.rd_en",     {31'd0, a_if.rd_en_o}, 32'd0);
    check_val("rst.error",     {31'd0, a_error},      32'd0);
    check_val("rst.stall",     {31'd0, a_stall},      32'd0);
    check_val("rst.locked",    {31'd0, a_locked},     32'd0);
    check_val("rst.words_ok",  a_ok,                  32'd0);
    check_val("rst.err_word",  a_err_word,            32'd0);
    check_val("rst.led_error", {31'd0, a_led_error},  32'd0);
    check_val("rst.led_blink", {31'd0, a_blink},      32'd0);
    sys_rst = 1'b0;
    edges = 0;

    // FIFO reset in progress with data present: no reads.
    load_words(16'h0000, 100, 0);
    busy_en = 0;
    repeat (10) begin
      tick();
      busy_en += int'(last_a_rd_en);
    end
    check_val("busy.rd_en_cycles", busy_en, 0);
    a_if.rst_busy_i = 1'b0;
    tick();
    tick();
    check_val("busy_fall.rd_en", {31'd0, last_a_rd_en}, 32'd1);
    check_val("busy_fall.locked", {31'd0, a_locked}, 32'd0);
    drain_a(0);
    check_model(0, "seq100");
    check_val("seq100.ok_const", a_ok, 32'd100);
    check_val("seq100.locked_const", {31'd0, a_locked}, 32'd1);
    check_blink("blink1");

    do_reset();
    load_words(16'hFFFE, 3, 0);
    drain_a(0);
    check_model(0, "wrap");
    check_val("wrap.ok_const", a_ok, 32'd3);
    check_val("wrap.error_const", {31'd0, a_error}, 32'd0);
    check_blink("blink2");

    do_reset();
    a_lat = 2;
    a_q.push_back(32'h0010_0011);
    a_q.push_back(32'h0013_0014);
    a_q.push_back(32'h0015_0016);
    drain_a(0);
    check_model(0, "inject");
    check_val("inject.err_word_const", a_err_word, 32'h0013_0014);
    check_val("inject.err_exp_const", {16'd0, a_err_exp}, 32'h0000_0012);
    check_val("inject.ok_const", a_ok, 32'd2);
    check_val("inject.led_error", {31'd0, a_led_error}, 32'd1);

    // Asynchronous clear between clock edges.
    #2;
    sys_rst = 1'b1;
    #1;
    check_val("async_rst.error",    {31'd0, a_error},      32'd0);
    check_val("async_rst.words_ok", a_ok,                  32'd0);
    check_val("async_rst.err_word", a_err_word,            32'd0);
    check_val("async_rst.locked",   {31'd0, a_locked},     32'd0);
    check_val("async_rst.led_err",  {31'd0, a_led_error},  32'd0);
    do_reset();

    for (int r = 0; r < 8; r++) begin
      a_lat     = 1 + int'($urandom_range(1));
      a_gap_pct = int'($urandom_range(40));
      load_words(16'($urandom()), 5 + int'($urandom_range(20)), 10);
      a_if.rst_busy_i = 1'b1;
      tick();
      check_val($sformatf("rnd%0d.busy_rd_en", r), {31'd0, last_a_rd_en}, 32'd0);
      tick();
      check_val($sformatf("rnd%0d.busy_locked", r), {31'd0, a_locked}, 32'd0);
      a_if.rst_busy_i = 1'b0;
      model_resync(0);
      drain_a(10);
      check_model(0, $sformatf("rnd%0d", r));
    end

    a_lat = 1;
    a_gap_pct = 0;
    load_words(16'h1234, 4, 0);
    drain_a(0);
    repeat (995) tick();
    check_val("wd.stall_before", {31'd0, a_stall}, 32'd0);
    repeat (40) tick();
    check_val("wd.stall_after", {31'd0, a_stall}, 32'd1);
    check_val("wd.led_error", {31'd0, a_led_error}, 32'd1);
    check_blink("blink3");

    do_reset();
    load_words(16'h4000, 4, 0);
    drain_a(0);
    a_enable = 1'b0;
    repeat (1100) tick();
    check_val("wd_dis.stall", {31'd0, a_stall}, 32'd0);
    check_model(0, "wd_dis");

    // RD_GAP=2 instance: one read every third cycle, then a mid-stream FIFO reset.
    b_enable = 1'b1;
    repeat (8) tick();
    cnt = 0;
    last = -1;
    mn = 1000;
    mx = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (last_b_rd_en) begin
        cnt++;
        if (last >= 0) begin
          if (i - last < mn) mn = i - last;
          if (i - last > mx) mx = i - last;
        end
        last = i;
      end
    end
    check_val("gap.pulses", cnt, 10);
    check_val("gap.min", mn, 3);
    check_val("gap.max", mx, 3);
    repeat (6) tick();
    b_if.rst_busy_i = 1'b1;
    tick();
    check_val("b_busy.rd_en", {31'd0, last_b_rd_en}, 32'd0);
    tick();
    check_val("b_busy.locked", {31'd0, b_locked}, 32'd0);
    b_if.rst_busy_i = 1'b0;
    b_cnt = b_cnt + 16'd1000;
    model_resync(1);
    repeat (30) tick();
    b_enable = 1'b0;
    repeat (4) tick();
    check_model(1, "b_resync");
    check_val("b_resync.error_kept", {31'd0, b_error}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
